// File: rtl/d_alu_wb_stage_pkg.sv
// Shared opcode map, destination classes and opcode classifier for the FP ALU writeback stage.
package d_alu_pkg;

  localparam logic [4:0] OP_FADD      = 5'd0;
  localparam logic [4:0] OP_FSUB      = 5'd1;
  localparam logic [4:0] OP_FMUL      = 5'd2;
  localparam logic [4:0] OP_FDIV      = 5'd3;
  localparam logic [4:0] OP_FSQRT     = 5'd4;
  localparam logic [4:0] OP_FMIN      = 5'd5;
  localparam logic [4:0] OP_FMAX      = 5'd6;
  localparam logic [4:0] OP_FSGNJ     = 5'd7;
  localparam logic [4:0] OP_FSGNJN    = 5'd8;
  localparam logic [4:0] OP_FSGNJX    = 5'd9;
  localparam logic [4:0] OP_FMADD     = 5'd10;
  localparam logic [4:0] OP_FMSUB     = 5'd11;
  localparam logic [4:0] OP_FNMADD    = 5'd12;
  localparam logic [4:0] OP_FNMSUB    = 5'd13;
  localparam logic [4:0] OP_FEQ       = 5'd14;
  localparam logic [4:0] OP_FLT       = 5'd15;
  localparam logic [4:0] OP_FLE       = 5'd16;
  localparam logic [4:0] OP_FCVT_S_D  = 5'd17;
  localparam logic [4:0] OP_FCVT_D_W  = 5'd18;
  localparam logic [4:0] OP_FCVT_D_WU = 5'd19;
  localparam logic [4:0] OP_FCVT_D_L  = 5'd20;
  localparam logic [4:0] OP_FCVT_W_D  = 5'd21;
  localparam logic [4:0] OP_FCVT_WU_D = 5'd22;
  localparam logic [4:0] OP_FCVT_D_LU = 5'd23;
  localparam logic [4:0] OP_FCVT_D_S  = 5'd24;
  localparam logic [4:0] OP_FCVT_L_D  = 5'd25;
  localparam logic [4:0] OP_FCVT_LU_D = 5'd26;
  localparam logic [4:0] OP_FCLASS    = 5'd27;
  localparam logic [4:0] OP_FMV_X_D   = 5'd28;
  localparam logic [4:0] OP_FMV_D_X   = 5'd29;
  localparam logic [4:0] OP_RSV0      = 5'd30;
  localparam logic [4:0] OP_RSV1      = 5'd31;

  // FIFO entry layout: {is_fp, rd[4:0], data[63:0]}
  localparam int ENTRY_W = 70;

  typedef enum logic [1:0] {DST_FP, DST_FS, DST_INT, DST_ILLEGAL} dst_class_e;

  function automatic dst_class_e op_dst_class(input logic [4:0] alu_op);
    dst_class_e cls;
    case (alu_op)
      OP_FEQ, OP_FLT, OP_FLE, OP_FCVT_W_D, OP_FCVT_WU_D,
      OP_FCVT_L_D, OP_FCVT_LU_D, OP_FCLASS, OP_FMV_X_D: cls = DST_INT;
      OP_FCVT_S_D:                                      cls = DST_FS;
      OP_RSV0, OP_RSV1:                                 cls = DST_ILLEGAL;
      default:                                          cls = DST_FP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/d_alu_wb_stage_if.sv
// ALU-result input and register-file writeback output bundle of the writeback stage.
interface d_alu_wb_stage_if #(parameter int CNT_W = 32);
  // Both sides are valid/ready: a transfer happens on a rising edge where valid && ready.
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_alu_op;
  logic [4:0]       in_rd;
  logic [63:0]      in_result;
  logic [31:0]      in_fs_result;
  logic [63:0]      in_int_result;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic             out_is_fp;
  logic [4:0]       out_rd;
  logic [63:0]      out_data;
  logic             illegal_op;
  logic [CNT_W-1:0] retired_cnt;

  modport slave (
    input  in_valid, in_alu_op, in_rd, in_result, in_fs_result, in_int_result,
    input  flush, out_ready,
    output in_ready, out_valid, out_is_fp, out_rd, out_data, illegal_op, retired_cnt
  );

  modport master (
    output in_valid, in_alu_op, in_rd, in_result, in_fs_result, in_int_result,
    output flush, out_ready,
    input  in_ready, out_valid, out_is_fp, out_rd, out_data, illegal_op, retired_cnt
  );
endinterface

// File: rtl/d_wb_fifo.sv
// Generic DEPTH x W synchronous FIFO with flush; head reads as zero while empty.
module d_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 70
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;
    assign o_data  = o_empty ? '0 : r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end
endmodule

// File: rtl/d_alu_wb_stage.sv
// FP ALU writeback stage: classify, format and buffer results for the register-file arbiter.
// Optional build macro D_WB_NANBOX_EN NaN-boxes single-precision results.
module d_alu_wb_stage
    import d_alu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input logic              clk,
    input logic              rst,
    d_alu_wb_stage_if.slave  bus
);
`ifdef D_WB_NANBOX_EN
    localparam logic [31:0] FS_UPPER = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] FS_UPPER = 32'h0000_0000;
`endif

    dst_class_e         w_cls;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [63:0]        w_data;
    logic               w_is_fp;
    logic [ENTRY_W-1:0] w_head;
    logic               w_empty;
    logic               w_full;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_retired;

    assign w_cls    = op_dst_class(bus.in_alu_op);
    assign w_accept = bus.in_valid && bus.in_ready;
    // x0 is hardwired zero, so integer writes to it are dropped; f0 is a real register.
    assign w_push   = w_accept && !bus.flush && (w_cls != DST_ILLEGAL) &&
                      !((w_cls == DST_INT) && (bus.in_rd == 5'd0));
    assign w_is_fp  = (w_cls != DST_INT);

    always_comb begin
        w_data = bus.in_result;
        case (w_cls)
            DST_INT: w_data = bus.in_int_result;
            DST_FS:  w_data = {FS_UPPER, bus.in_fs_result};
            default: w_data = bus.in_result;
        endcase
    end

    d_wb_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.flush),
        .i_push  (w_push),
        .i_data  ({w_is_fp, bus.in_rd, w_data}),
        .i_pop   (bus.out_ready),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // in_ready depends only on registered occupancy, never on out_ready.
    assign bus.in_ready    = !w_full;
    assign bus.out_valid   = !w_empty;
    assign bus.out_is_fp   = w_head[69];
    assign bus.out_rd      = w_head[68:64];
    assign bus.out_data    = w_head[63:0];
    assign bus.illegal_op  = r_illegal;
    assign bus.retired_cnt = r_retired;
    assign w_pop           = bus.out_valid && bus.out_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
            r_retired <= '0;
        end else begin
            r_illegal <= w_accept && !bus.flush && (w_cls == DST_ILLEGAL);
            if (w_pop) r_retired <= r_retired + 1'b1;
        end
    end
endmodule

// File: tb/tb_d_alu_wb_stage.sv
// Self-checking bench for d_alu_wb_stage: directed scenarios followed by randomized traffic.
module tb_d_alu_wb_stage;
    localparam int DEPTH = 2;
    localparam int CNT_W = 32;
`ifdef D_WB_NANBOX_EN
    localparam logic [31:0] FS_HI = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] FS_HI = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    d_alu_wb_stage_if #(.CNT_W(CNT_W)) bus ();

    d_alu_wb_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [69:0]      exp_q[$];
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_ill;
    int               checks   = 0;
    int               failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: applies one rising edge using the inputs the bench is driving.
    task automatic model_edge();
        logic        acc;
        logic        pop;
        logic        keep;
        logic        fp;
        logic [63:0] d;
        if (rst) begin
            exp_q.delete();
            exp_cnt = '0;
            exp_ill = 1'b0;
            return;
        end
        acc = bus.in_valid && (exp_q.size() < DEPTH);
        pop = bus.out_ready && (exp_q.size() > 0);
        if (bus.flush) begin
            exp_q.delete();
            exp_ill = 1'b0;
            return;
        end
        if (pop) begin
            void'(exp_q.pop_front());
            exp_cnt = exp_cnt + 1;
        end
        exp_ill = acc && (bus.in_alu_op >= 5'd30);
        keep = acc;
        fp   = 1'b1;
        d    = bus.in_result;
        if (bus.in_alu_op inside {[5'd14:5'd16], 5'd21, 5'd22, [5'd25:5'd28]}) begin
            fp   = 1'b0;
            d    = bus.in_int_result;
            keep = acc && (bus.in_rd != 5'd0);
        end else if (bus.in_alu_op == 5'd17) begin
            d = {FS_HI, bus.in_fs_result};
        end else if (bus.in_alu_op >= 5'd30) begin
            keep = 1'b0;
        end
        if (keep) exp_q.push_back({fp, bus.in_rd, d});
    endtask

    task automatic check_all();
        logic [69:0] h;
        h = (exp_q.size() > 0) ? exp_q[0] : 70'd0;
        chk("in_ready",    64'(bus.in_ready),    64'(exp_q.size() < DEPTH));
        chk("out_valid",   64'(bus.out_valid),   64'(exp_q.size() > 0));
        chk("out_is_fp",   64'(bus.out_is_fp),   64'(h[69]));
        chk("out_rd",      64'(bus.out_rd),      64'(h[68:64]));
        chk("out_data",    bus.out_data,         h[63:0]);
        chk("illegal_op",  64'(bus.illegal_op),  64'(exp_ill));
        chk("retired_cnt", 64'(bus.retired_cnt), 64'(exp_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst               = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_alu_op     = 5'd0;
        bus.in_rd         = 5'd0;
        bus.in_result     = 64'd0;
        bus.in_fs_result  = 32'd0;
        bus.in_int_result = 64'd0;
        bus.flush         = 1'b0;
        bus.out_ready     = 1'b0;
        exp_cnt           = '0;
        exp_ill           = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);

        // FP result, one-cycle latency, then retire
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_alu_op = 5'b00000;
        bus.in_rd     = 5'd3;
        bus.in_result = 64'h4000_0000_0000_0000;
        tick();
        bus.in_valid = 1'b0;
        chk("fadd_valid", 64'(bus.out_valid), 64'd1);
        chk("fadd_is_fp", 64'(bus.out_is_fp), 64'd1);
        chk("fadd_rd", 64'(bus.out_rd), 64'd3);
        chk("fadd_data", bus.out_data, 64'h4000_0000_0000_0000);
        tick();
        chk("fadd_retired", 64'(bus.retired_cnt), 64'd1);

        // single-precision conversion result formatting
        bus.out_ready    = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_alu_op    = 5'b10001;
        bus.in_rd        = 5'd7;
        bus.in_fs_result = 32'h3F80_0000;
        tick();
        bus.in_valid = 1'b0;
        chk("fcvt_s_data", bus.out_data, {FS_HI, 32'h3F80_0000});
        bus.out_ready = 1'b1;
        tick();

        // backpressure: third push held while full
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_alu_op = 5'd2;
        for (int i = 0; i < 3; i++) begin
            bus.in_rd     = 5'(10 + i);
            bus.in_result = 64'(100 + i);
            tick();
        end
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_head_rd", 64'(bus.out_rd), 64'd10);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("drain_second_rd", 64'(bus.out_rd), 64'd11);
        tick();
        chk("drain_retired", 64'(bus.retired_cnt), 64'd4);

        // x0 suppression, then a real integer write
        bus.in_valid      = 1'b1;
        bus.in_alu_op     = 5'b01110;
        bus.in_rd         = 5'd0;
        bus.in_int_result = 64'd1;
        tick();
        bus.in_valid = 1'b0;
        chk("x0_valid", 64'(bus.out_valid), 64'd0);
        chk("x0_retired", 64'(bus.retired_cnt), 64'd4);
        bus.in_valid = 1'b1;
        bus.in_rd    = 5'd5;
        tick();
        bus.in_valid = 1'b0;
        chk("int_is_fp", 64'(bus.out_is_fp), 64'd0);
        chk("int_data", bus.out_data, 64'd1);
        tick();

        // illegal opcode pulse
        bus.in_valid  = 1'b1;
        bus.in_alu_op = 5'b11111;
        tick();
        bus.in_valid = 1'b0;
        chk("illegal_pulse", 64'(bus.illegal_op), 64'd1);
        chk("illegal_valid", 64'(bus.out_valid), 64'd0);
        tick();
        chk("illegal_clear", 64'(bus.illegal_op), 64'd0);

        // flush with two buffered entries and a same-cycle push
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_alu_op = 5'd0;
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_retired", 64'(bus.retired_cnt), 64'd5);

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            bus.in_valid      = ($urandom_range(0, 3) != 0);
            bus.in_alu_op     = 5'($urandom_range(0, 31));
            bus.in_rd         = 5'($urandom_range(0, 3));
            bus.in_result     = {$urandom, $urandom};
            bus.in_fs_result  = $urandom;
            bus.in_int_result = {$urandom, $urandom};
            bus.out_ready     = ($urandom_range(0, 3) != 0);
            bus.flush         = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
